// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: CPU writes to I/O $00 are queued in a small
// FIFO and sent as 8N1 frames on tx; I/O $01 reads back a status byte.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_en,
  input  logic       we,
  input  logic       oe,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic       wr_sel, rd_sel, full, empty, busy;
  logic       pop, push, drop, baud_last;
  logic [7:0] status;

  // A simultaneous we/oe access is treated purely as a write.
  assign wr_sel = io_en & we & (addr == 8'h00);
  assign rd_sel = io_en & oe & ~we & (addr == 8'h01);

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != IDLE);
  assign baud_last = (baud_q == BAUD_LAST);

  // A pop on the same edge frees a slot, so a write to a full FIFO is kept.
  assign push = wr_sel & (~full | pop);
  assign drop = wr_sel & full & ~pop;

  // While reset is held the registers may not be settled yet; report reset status.
  assign status   = !reset ? 8'h02 : {4'b0000, busy, overflow_q, empty, full};
  assign data_oe  = rd_sel;
  assign data_out = rd_sel ? status : 8'h00;
  assign tx       = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    if (state_q != IDLE) begin
      baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) state_d = DATA;
      end
      DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = 3'd0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (rd_sel) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: an abstract frame-timing model predicts accepted bytes
// and status; a serial monitor decodes tx and checks against the expected queue.
module tb_io_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       io_en = 1'b0, we = 1'b0, oe = 1'b0;
  logic [7:0] addr = 8'h00, data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe, tx;

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset_n), .io_en(io_en), .we(we), .oe(oe),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .data_oe(data_oe), .tx(tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_seen = 0;
  int starts[$];
  logic [7:0] pend[$];
  logic [7:0] exp_q[$];
  bit in_frame = 1'b0;
  int frame_left = 0;
  bit m_ovf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_status();
    return {4'b0000, in_frame, m_ovf, pend.size() == 0, pend.size() == DEPTH};
  endfunction

  // Reference model: a frame is FRAME cycles long and the next queued byte
  // starts either when the line is idle or on the last cycle of a frame.
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      pend.delete();
      in_frame   = 1'b0;
      frame_left = 0;
      m_ovf      = 1'b0;
    end else begin
      bit wr, rd, pop_now, was_full;
      wr       = io_en && we && addr == 8'h00;
      rd       = io_en && oe && !we && addr == 8'h01;
      was_full = (pend.size() == DEPTH);
      pop_now  = pend.size() > 0 && (!in_frame || frame_left == 1);
      if (pop_now) begin
        exp_q.push_back(pend.pop_front());
        in_frame   = 1'b1;
        frame_left = FRAME;
      end else if (in_frame) begin
        frame_left--;
        if (frame_left == 0) in_frame = 1'b0;
      end
      if (wr && (!was_full || pop_now)) pend.push_back(data_in);
      if (wr && was_full && !pop_now) m_ovf = 1'b1;
      else if (rd) m_ovf = 1'b0;
    end
  end

  // Serial monitor: decodes 8N1 frames at mid-bit.
  initial begin
    logic prev_tx;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n && tx === 1'b0 && prev_tx === 1'b1) begin
        logic [7:0] b;
        bit abort;
        b = 8'h00;
        abort = 1'b0;
        starts.push_back(cyc);
        for (int off = 0; off < FRAME; off++) begin
          if (off > 0) @(negedge clk);
          if (!reset_n) begin
            abort = 1'b1;
            break;
          end
          if (off % CPB == CPB / 2) begin
            if (off / CPB == 0) chk("start_bit", tx, 0);
            else if (off / CPB == 9) chk("stop_bit", tx, 1);
            else b[off / CPB - 1] = tx;
          end
        end
        if (abort) begin
          $display("frame aborted by reset at cycle %0d", cyc);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          frames_seen++;
          $display("frame %0d: byte %02h at cycle %0d", frames_seen, b, cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
          end else begin
            chk("frame_byte", b, exp_q.pop_front());
          end
        end
      end
      prev_tx = tx;
    end
  end

  task automatic write_byte(input logic [7:0] b);
    io_en = 1'b1; we = 1'b1; oe = 1'b0; addr = 8'h00; data_in = b;
    @(negedge clk);
    io_en = 1'b0; we = 1'b0;
  endtask

  // use_const selects a fixed expected status instead of the model's prediction.
  task automatic read_status(input string name, input bit use_const, input logic [7:0] c);
    logic [7:0] exp;
    io_en = 1'b1; oe = 1'b1; we = 1'b0; addr = 8'h01;
    #1;
    exp = use_const ? c : model_status();
    chk({name, "_oe"}, data_oe, 1);
    chk(name, data_out, exp);
    @(negedge clk);
    io_en = 1'b0; oe = 1'b0; addr = 8'h00;
    #1;
    chk({name, "_oe_after"}, data_oe, 0);
  endtask

  task automatic ignored_access(input string name, input logic w, input logic r, input logic [7:0] a);
    io_en = 1'b1; we = w; oe = r; addr = a; data_in = 8'h5A;
    #1;
    chk({name, "_oe"}, data_oe, 0);
    chk({name, "_data"}, data_out, 0);
    @(negedge clk);
    io_en = 1'b0; we = 1'b0; oe = 1'b0; addr = 8'h00;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!in_frame && pend.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_drain_timeout"}, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, f0, s0;
    repeat (2) @(negedge clk);
    read_status("reset_status", 1'b1, 8'h02);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    read_status("idle_status", 1'b1, 8'h02);

    // Single frame and first-bit latency
    write_byte(8'hA5);
    t0 = cyc;
    chk("tx_idle_after_write", tx, 1);
    @(negedge clk);
    chk("tx_start_latency", tx, 0);
    wait_drain("single");
    read_status("single_done", 1'b1, 8'h02);
    chk("single_frames", frames_seen, 1);

    // Three back-to-back frames
    f0 = frames_seen;
    s0 = starts.size();
    write_byte(8'h01);
    t0 = cyc;
    write_byte(8'h02);
    write_byte(8'h03);
    while (cyc < t0 + 3 * FRAME) @(negedge clk);
    read_status("b2b_busy_end", 1'b1, 8'h0A);
    read_status("b2b_idle", 1'b1, 8'h02);
    wait_drain("b2b");
    chk("b2b_frames", frames_seen - f0, 3);
    if (starts.size() >= s0 + 3) begin
      chk("b2b_gap1", starts[s0 + 1] - starts[s0], FRAME);
      chk("b2b_gap2", starts[s0 + 2] - starts[s0 + 1], FRAME);
    end else begin
      chk("b2b_start_count", starts.size() - s0, 3);
    end

    // Overflow: six writes while the first frame is in flight
    f0 = frames_seen;
    for (int i = 0; i < 6; i++) write_byte(8'($urandom));
    read_status("ovf_status", 1'b1, 8'h0D);
    read_status("ovf_cleared", 1'b1, 8'h09);
    wait_drain("ovf");
    chk("ovf_frames", frames_seen - f0, 5);
    read_status("ovf_done", 1'b1, 8'h02);

    // Ignored accesses
    f0 = frames_seen;
    ignored_access("wr_addr01", 1'b1, 1'b0, 8'h01);
    ignored_access("rd_addr00", 1'b0, 1'b1, 8'h00);
    ignored_access("rd_addr02", 1'b0, 1'b1, 8'h02);
    ignored_access("wr_addr02", 1'b1, 1'b0, 8'h02);
    repeat (FRAME) @(negedge clk);
    chk("ignored_tx", tx, 1);
    chk("ignored_frames", frames_seen - f0, 0);
    read_status("ignored_status", 1'b1, 8'h02);

    // Reset in the middle of data bit 3
    f0 = frames_seen;
    write_byte(8'h3C);
    t0 = cyc;
    write_byte(8'h11);
    write_byte(8'h22);
    while (cyc < t0 + 1 + 4 * CPB + 1) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midframe_reset_tx", tx, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    read_status("after_reset_status", 1'b1, 8'h02);
    repeat (3 * FRAME) @(negedge clk);
    chk("after_reset_frames", frames_seen - f0, 0);
    chk("after_reset_tx", tx, 1);
    chk("after_reset_expq", exp_q.size(), 0);

    // Randomised traffic with occasional model-checked status reads
    for (int n = 0; n < 40; n++) begin
      int sel, gap;
      sel = $urandom_range(0, 9);
      if (sel < 7) begin
        logic [7:0] b;
        b = 8'($urandom);
        $display("rand write %02h", b);
        write_byte(b);
      end else begin
        read_status("rand_status", 1'b0, 8'h00);
      end
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 60) : $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end
    wait_drain("random");
    read_status("final_status", 1'b0, 8'h00);
    chk("final_tx", tx, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped serial output port on the machine's I/O space, replacing the simulation-only debug printer as the consumer of CPU `OUT` cycles. The CPU writes bytes to I/O address $00; the block queues them in a small FIFO and shifts each out as an 8N1 UART frame on `tx`. A status register at I/O address $01 lets software poll for space before writing. The top level drives the shared data bus from `data_out` when `data_oe` is high.

## Interface

- `CLKS_PER_BIT`, 4: `clk` cycles per serial bit; legal values are ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of two, ≥ 2.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on rising edge of `clk`).
- `io_en`  in  1  I/O access qualifier (`mem_io & mem_clk` resynchronised by top level); high for exactly one `clk` cycle per access.
- `we`  in  1  write access (CPU `c_ri`).
- `oe`  in  1  read access (CPU `c_ro`).
- `addr`  in  8  I/O address from `addr_bus`.
- `data_in`  in  8  byte on data bus.
- `data_out`  out  8  read data; combinational.
- `data_oe`  out  1  top level drives bus with `data_out` when high; combinational.
- `tx`  out  1  serial line, idle high; registered.

## Operation

- Write select: `io_en & we & addr==$00`. The byte is pushed to the FIFO at the clock edge.
- Read select: `io_en & oe & addr==$01`. `data_oe`=1 and `data_out`=STATUS. Otherwise `data_oe`=0 and `data_out`=$00.
- Accesses to any other address, reads of $00, and writes to $01 are ignored.
- STATUS byte:
  - bit0 = FIFO full.
  - bit1 = FIFO empty.
  - bit2 = overflow, sticky.
  - bit3 = tx busy (state ≠ IDLE).
  - bits7:4 = 0.
- Overflow:
  - A write while the FIFO is full is dropped and sets overflow. FIFO contents are unchanged.
  - Overflow clears on the clock edge that ends a status read.
  - If a dropped write and a status read coincide, the set wins.
- FIFO:
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits; pointers wrap modulo depth.
  - Occupancy count has log2(FIFO_DEPTH)+1 bits.
  - A push and a pop on the same edge both take effect and the count is unchanged. This also applies when the FIFO is full: the pop frees the slot, so the write is accepted, not dropped.
- Transmit FSM: IDLE → START → DATA → STOP → (IDLE or START).
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0], LSB first. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After 8 bits go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
    - At the end of STOP, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps; it runs only outside IDLE.

## Timing

- Reset values: `tx`=1, FSM=IDLE, FIFO empty, pointers 0, overflow 0. `data_oe`=0; a status read during reset returns $02.
- Reset asserted mid-frame aborts the frame: `tx` returns high on the next edge and queued bytes are discarded.
- Latency:
  - Write accepted at edge N.
  - FIFO non-empty after N; IDLE pops at edge N+1.
  - `tx` falls after edge N+1 if the FSM was idle.
- Frame length is exactly 10·CLKS_PER_BIT cycles: 1 start bit, 8 data bits, 1 stop bit.
- Busy (bit3) goes high after the pop edge and low after the final STOP edge when no byte is queued.
- Status read data is valid in the same cycle as `io_en`; it reflects register state before that cycle's edge.
- A write and a status read in the same cycle cannot occur (`we` and `oe` are exclusive). If both are high, the block treats the access as a write only.

## Test plan

- Reset, then status read → $02, `tx`=1, `data_oe`=1 only during the read cycle.
- CLKS_PER_BIT=4, write $A5 → `tx` low 1 cycle after the write edge. Bits 1,0,1,0,0,1,0,1 follow, each 4 cycles, then a stop bit; 40 cycles total. Status afterwards = $02.
- Write $01,$02,$03 on consecutive accesses → three contiguous frames with no idle gap. Busy stays high for 120 cycles.
- Write 6 bytes while the first frame is in flight (FIFO_DEPTH=4):
  - Bytes 1–5 are accepted (one popped, four queued); byte 6 is dropped.
  - Status shows full+overflow+busy = $0D.
  - Next status read clears overflow → $09.
  - Exactly 5 frames are transmitted.
- Assert reset in the middle of DATA bit 3 → `tx`=1 next cycle. FIFO is emptied and no further frames appear.
- Accesses to address $02, a read of $00, and a write to $01 → no FIFO change, `data_oe`=0, `tx` unchanged.
